// File: rtl/riscv_structures_pkg.sv
// Shared RISC-V datapath types: machine word width and the word typedef.
package riscv_structures;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/riscv_data_memory.sv
// Word-organised data RAM for the memory stage: full-word writes, registered
// read-first read port, out-of-range accesses ignored (writes) or zero (reads).
module riscv_data_memory
    import riscv_structures::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth_pow2
        $error("riscv_data_memory: DEPTH_WORDS must be a power of two");
    end

    if (DEPTH_WORDS < 4) begin : g_bad_depth_min
        $error("riscv_data_memory: DEPTH_WORDS must be at least 4");
    end

    word_t mem [DEPTH_WORDS];

    // Array starts at zero.
    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            mem[i] = '0;
        end
    end

    logic [IDX_W-1:0] idx_c;
    logic             in_range_c;
    logic             unused_c;

    assign idx_c      = address[2 +: IDX_W];
    assign in_range_c = (address[XLEN-1:IDX_W+2] == '0);
    assign unused_c   = ^address[1:0];

    // Array write; no reset so synthesis can map it to block RAM.
    always_ff @(posedge clk) begin
        if (!rst && write_enable && in_range_c) begin
            mem[idx_c] <= write_data;
        end
    end

    // Registered read port, read-first against a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (in_range_c) begin
            read_data <= mem[idx_c];
        end else begin
            read_data <= '0;
        end
    end

endmodule

// File: tb/tb_riscv_data_memory.sv
// Self-checking bench for riscv_data_memory: directed vector table, reset
// corner sequences and a model-backed random phase through a scoreboard queue.
module tb_riscv_data_memory;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [31:0] read_data;

    int errors;
    int checks;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14];

    riscv_data_memory #(
        .DEPTH_WORDS(DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .write_data  (write_data),
        .write_enable(write_enable),
        .read_data   (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: read_data=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    // One access cycle: drive at negedge, push expectation, compare after the edge.
    task automatic step(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        address      = a;
        write_data   = wd;
        write_enable = we;
        exp_q.push_back(exp);
        if (we && in_rng(a)) model[a[11:2]] = wd;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, read_data, e);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [31:0] e;

        errors = 0;
        checks = 0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'h0;

        vecs[0]  = '{32'h0000_0000, 32'h0,          1'b0, 32'h0000_0000};
        vecs[1]  = '{32'h0000_0010, 32'hDEADBEEF,   1'b1, 32'h0000_0000};
        vecs[2]  = '{32'h0000_0010, 32'h0,          1'b0, 32'hDEADBEEF};
        vecs[3]  = '{32'h0000_0014, 32'h0,          1'b0, 32'h0000_0000};
        vecs[4]  = '{32'h0000_0020, 32'h12345678,   1'b1, 32'h0000_0000};
        vecs[5]  = '{32'h0000_0021, 32'h0,          1'b0, 32'h12345678};
        vecs[6]  = '{32'h0000_0022, 32'h0,          1'b0, 32'h12345678};
        vecs[7]  = '{32'h0000_0023, 32'h0,          1'b0, 32'h12345678};
        vecs[8]  = '{32'h0000_0030, 32'hAAAA0000,   1'b1, 32'h0000_0000};
        vecs[9]  = '{32'h0000_0030, 32'h5555FFFF,   1'b1, 32'hAAAA0000};
        vecs[10] = '{32'h0000_0030, 32'h0,          1'b0, 32'h5555FFFF};
        vecs[11] = '{32'h0000_1000, 32'hCAFEBABE,   1'b1, 32'h0000_0000};
        vecs[12] = '{32'h0000_1000, 32'h0,          1'b0, 32'h0000_0000};
        vecs[13] = '{32'h0000_0000, 32'h0,          1'b0, 32'h0000_0000};

        rst          = 1'b1;
        address      = 32'h0;
        write_data   = 32'h0;
        write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].exp);
        end

        // Async reset clears a non-zero read_data before any clock edge.
        step("pre_rst_read", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_clear", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_read", 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Write coinciding with reset is dropped.
        @(negedge clk);
        address      = 32'h40;
        write_data   = 32'h0BADF00D;
        write_enable = 1'b1;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        check("rst_write_rd", read_data, 32'h0);
        @(negedge clk);
        rst          = 1'b0;
        write_enable = 1'b0;
        step("rst_write_dropped", 32'h40, 32'h0, 1'b0, 32'h0);
        step("rst_write_hold", 32'h40, 32'h0, 1'b0, 32'h0);

        // Random mix against the reference model, including out-of-range addresses.
        for (int n = 0; n < 60; n++) begin
            a  = $urandom_range(32'h1FFF, 0);
            if (n % 7 == 3) a = $urandom();
            wd = $urandom();
            we = 1'($urandom_range(1, 0));
            e  = in_rng(a) ? model[a[11:2]] : 32'h0;
            step($sformatf("rand%0d", n), a, wd, we, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
